// File: rtl/seq_run_generator_pkg.sv
// Shared types for the run generator.
//   gen_state_e : generator FSM state (IDLE, EMIT)
//   run_desc_t  : run descriptor {bit value, run length}
//   MATCH_LEN_DEF : default equal-bit run length that predicts detector z
// The descriptor length field is sized for the widest supported RUN_W
// (RUN_W_MAX). Narrower instances zero-extend into it, and the constant
// upper bits are trimmed by synthesis.
package seq_pkg;

  localparam int MATCH_LEN_DEF = 4;
  localparam int RUN_W_MAX     = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } gen_state_e;

  typedef struct packed {
    logic                 bit_val;
    logic [RUN_W_MAX-1:0] len;
  } run_desc_t;

endpackage

// File: rtl/seq_run_generator_fifo.sv
// run_fifo: synchronous FIFO holding run descriptors.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties FIFO)
//   i_push, i_din   : write request and data (ignored when full)
//   i_pop           : read request (ignored when empty)
//   o_dout          : head entry (valid while !o_empty)
//   o_full, o_empty : occupancy flags, derived from registered count only
module run_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage has no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/seq_run_generator.sv
// seq_run_generator: turns queued run descriptors {bit, len} into a serial
// bit stream for a sequence detector and predicts the detector's z output.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : descriptor handshake
//   in_bit, in_len      : descriptor bit value and run length (0 = dropped)
//   w, w_valid          : serial stream and its qualifier
//   expect_z            : predicted detector z (registered)
//   busy                : FIFO non-empty or a run is being emitted
//   dbg_state           : generator FSM state
//
// Handshake: a descriptor transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state (never on in_valid), is low while
// reset is applied, and is low whenever the FIFO is full even if a pop happens
// in the same cycle.
module seq_run_generator
  import seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RUN_W      = 4,
  parameter int MATCH_LEN  = MATCH_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [RUN_W-1:0] in_len,
  output logic             w,
  output logic             w_valid,
  output logic             expect_z,
  output logic             busy,
  output gen_state_e       dbg_state
);

  localparam int HIST_W = $clog2(MATCH_LEN + 1);
  localparam int DW     = $bits(run_desc_t);

  logic                 r_rdy_en;
  gen_state_e           r_state;
  logic [RUN_W_MAX-1:0] r_cnt;
  logic                 r_bit;
  logic                 r_w;
  logic                 r_w_valid;
  logic                 r_z;
  logic [HIST_W-1:0]    r_hist;
  logic                 r_last_bit;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_last;
  run_desc_t            w_push_desc;
  run_desc_t            w_head;
  logic [DW-1:0]        w_head_raw;
  logic [HIST_W-1:0]    w_hist_nxt;

  // Goes high on the first edge after reset is released.
  always_ff @(posedge clk) begin
    r_rdy_en <= !reset;
  end

  assign in_ready    = r_rdy_en && !w_full;
  // Zero-length runs complete the handshake but never enter the FIFO.
  assign w_push      = in_valid && in_ready && (in_len != '0);
  assign w_push_desc = '{bit_val: in_bit, len: RUN_W_MAX'(in_len)};
  assign w_head      = run_desc_t'(w_head_raw);
  assign w_last      = (r_cnt == RUN_W_MAX'(1));
  // Pop when idle, or on the last cycle of a run so the next run follows
  // with no gap.
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_last);

  run_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_push_desc),
    .i_pop   (w_pop),
    .o_dout  (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Generator FSM. w/w_valid are registered from the state, so the stream
  // trails the EMIT state by one cycle: accept at t, load at t+1, first bit
  // visible from t+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit     <= 1'b0;
      r_w       <= 1'b0;
      r_w_valid <= 1'b0;
    end else begin
      r_w_valid <= (r_state == ST_EMIT);
      r_w       <= (r_state == ST_EMIT) && r_bit;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cnt   <= w_head.len;
            r_bit   <= w_head.bit_val;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_last) begin
            if (!w_empty) begin
              r_cnt <= w_head.len;
              r_bit <= w_head.bit_val;
            end else begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - RUN_W_MAX'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reference model of the detector: length of the current run of equal
  // stream bits, including this cycle's bit. r_hist == 0 means the previous
  // cycle carried no valid bit, so the next valid bit starts a fresh run.
  always_comb begin
    w_hist_nxt = '0;
    if (r_w_valid) begin
      if ((r_hist != '0) && (r_w == r_last_bit)) begin
        if (r_hist >= HIST_W'(MATCH_LEN)) begin
          w_hist_nxt = HIST_W'(MATCH_LEN);
        end else begin
          w_hist_nxt = r_hist + HIST_W'(1);
        end
      end else begin
        w_hist_nxt = HIST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist     <= '0;
      r_last_bit <= 1'b0;
      r_z        <= 1'b0;
    end else begin
      r_hist     <= w_hist_nxt;
      r_last_bit <= r_w;
      r_z        <= r_w_valid && (w_hist_nxt == HIST_W'(MATCH_LEN));
    end
  end

  assign w         = r_w;
  assign w_valid   = r_w_valid;
  assign expect_z  = r_z;
  assign busy      = !w_empty || (r_state == ST_EMIT);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_run_generator.sv
module tb_seq_run_generator;
  import seq_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int RUN_W      = 4;
  localparam int MATCH_LEN  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic [RUN_W-1:0] in_len = '0;
  logic             in_ready;
  logic             w;
  logic             w_valid;
  logic             expect_z;
  logic             busy;
  gen_state_e       dbg_state;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Observed stream (one entry per w_valid cycle), index of the stream
  // position at each expect_z cycle, and count of contiguous bursts.
  logic       got_q[$];
  int         z_idx_q[$];
  int         n_starts = 0;
  logic       prev_wv = 1'b0;
  logic [0:0] exp_q[$];

  seq_run_generator #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .RUN_W      (RUN_W),
    .MATCH_LEN  (MATCH_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_len    (in_len),
    .w         (w),
    .w_valid   (w_valid),
    .expect_z  (expect_z),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (expect_z === 1'b1) z_idx_q.push_back(got_q.size());
    if (w_valid === 1'b1) begin
      got_q.push_back(w);
      if (!prev_wv) n_starts++;
    end
    prev_wv = (w_valid === 1'b1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one descriptor; called 1 time unit after an edge. Returns ok=1 if
  // the handshake completed within the cycle budget.
  task automatic push_desc(input logic b, input logic [RUN_W-1:0] len, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_bit = b;
    in_len = len;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  function automatic int count_ones(input int from);
    int n = 0;
    for (int i = from; i < got_q.size(); i++) if (got_q[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    bit ok;
    int s;
    int zs;
    int st;
    logic [8:0] pat;

    // ---- reset ----
    reset = 1'b1;
    repeat (3) tick();
    check("rst_w_valid", w_valid, 1'b0);
    check("rst_w", w, 1'b0);
    check("rst_expect_z", expect_z, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick();
    check("rel_in_ready", in_ready, 1'b1);

    // ---- single run {0,4}: latency and one z pulse ----
    s = got_q.size();
    zs = z_idx_q.size();
    push_desc(1'b0, 4'd4, ok);
    check("t1_push", ok, 1'b1);
    tick();
    check("t1_lat_w_valid", w_valid, 1'b0);
    check("t1_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t1_w_valid_%0d", i), w_valid, 1'b1);
      check($sformatf("t1_w_%0d", i), w, 1'b0);
      check($sformatf("t1_z_lo_%0d", i), expect_z, 1'b0);
    end
    tick();
    check("t1_end_w_valid", w_valid, 1'b0);
    check("t1_z_hi", expect_z, 1'b1);
    check("t1_end_busy", busy, 1'b0);
    tick();
    check("t1_z_fall", expect_z, 1'b0);
    check("t1_bits", got_q.size() - s, 4);
    check("t1_z_count", z_idx_q.size() - zs, 1);

    // ---- back-to-back {1,2},{0,3},{1,4} -> 11 000 1111 ----
    s = got_q.size();
    zs = z_idx_q.size();
    st = n_starts;
    push_desc(1'b1, 4'd2, ok);
    check("t2_push_a", ok, 1'b1);
    push_desc(1'b0, 4'd3, ok);
    check("t2_push_b", ok, 1'b1);
    push_desc(1'b1, 4'd4, ok);
    check("t2_push_c", ok, 1'b1);
    repeat (16) tick();
    pat = 9'b110001111;
    for (int i = 0; i < 9; i++) exp_q.push_back(pat[8-i]);
    check("t2_bits", got_q.size() - s, 9);
    check("t2_bursts", n_starts - st, 1);
    if (got_q.size() - s == 9) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("t2_stream_%0d", i), got_q[s+i], exp_q.pop_front());
      end
    end
    check("t2_z_count", z_idx_q.size() - zs, 1);
    if (z_idx_q.size() > zs) check("t2_z_pos", z_idx_q[zs], s + 9);

    // ---- {1,6}: z high after bits 4,5,6 ----
    s = got_q.size();
    zs = z_idx_q.size();
    push_desc(1'b1, 4'd6, ok);
    check("t3_push", ok, 1'b1);
    repeat (12) tick();
    check("t3_bits", got_q.size() - s, 6);
    check("t3_ones", count_ones(s), 6);
    check("t3_z_count", z_idx_q.size() - zs, 3);
    if (z_idx_q.size() - zs == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t3_z_pos_%0d", i), z_idx_q[zs+i], s + 4 + i);
      end
    end

    // ---- six {0,3} held back-to-back: FIFO fills, nothing lost ----
    s = got_q.size();
    zs = z_idx_q.size();
    st = n_starts;
    for (int k = 0; k < 6; k++) begin
      push_desc(1'b0, 4'd3, ok);
      check($sformatf("t4_push_%0d", k), ok, 1'b1);
    end
    check("t4_full_in_ready", in_ready, 1'b0);
    check("t4_full_busy", busy, 1'b1);
    repeat (30) tick();
    check("t4_bits", got_q.size() - s, 18);
    check("t4_bursts", n_starts - st, 1);
    check("t4_ones", count_ones(s), 0);
    check("t4_z_count", z_idx_q.size() - zs, 15);
    check("t4_busy_done", busy, 1'b0);
    check("t4_in_ready_done", in_ready, 1'b1);

    // ---- {1,0} dropped, then {0,2} ----
    s = got_q.size();
    zs = z_idx_q.size();
    push_desc(1'b1, 4'd0, ok);
    check("t5_push_zero", ok, 1'b1);
    check("t5_zero_not_queued", busy, 1'b0);
    push_desc(1'b0, 4'd2, ok);
    check("t5_push", ok, 1'b1);
    repeat (8) tick();
    check("t5_bits", got_q.size() - s, 2);
    check("t5_ones", count_ones(s), 0);
    check("t5_z_count", z_idx_q.size() - zs, 0);

    // ---- {1,8} aborted by reset during the third output cycle ----
    s = got_q.size();
    push_desc(1'b1, 4'd8, ok);
    check("t6_push", ok, 1'b1);
    repeat (4) tick();
    check("t6_third_valid", w_valid, 1'b1);
    reset = 1'b1;
    tick();
    check("t6_rst_w_valid", w_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_z", expect_z, 1'b0);
    check("t6_rst_in_ready", in_ready, 1'b0);
    check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick();
    check("t6_rel_in_ready", in_ready, 1'b1);
    check("t6_rel_w_valid", w_valid, 1'b0);
    repeat (10) tick();
    check("t6_bits", got_q.size() - s, 3);
    check("t6_busy_after", busy, 1'b0);

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
